// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared state encoding and NOP control constants for the hazard controller
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERR      = 2'd2
  } state_t;

  // Control bits zeroed when ID/EX takes a bubble
  typedef struct packed {
    logic reg_write;
    logic mem2reg;
    logic mem_read;
    logic mem_write;
  } ctrl_t;

  localparam ctrl_t      NOP_CTRL = '0;
  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - pipeline-side signals of the hazard controller
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             IDEX_MemRead_i;
  logic [4:0]       IDEX_RDaddr_i;
  logic [4:0]       IFID_RSaddr_i;
  logic [4:0]       IFID_RTaddr_i;
  logic             Branch_taken_i;
  logic             DMemReq_i;
  logic             DMemAck_i;
  logic             PC_write_o;
  logic             IFID_write_o;
  logic             IFID_flush_o;
  logic             IDEX_bubble_o;
  logic             Hold_o;
  logic             MEMWB_bubble_o;
  logic             Err_o;
  logic [CNT_W-1:0] Stall_cnt_o;

  modport master (
    output IDEX_MemRead_i, IDEX_RDaddr_i, IFID_RSaddr_i, IFID_RTaddr_i,
           Branch_taken_i, DMemReq_i, DMemAck_i,
    input  PC_write_o, IFID_write_o, IFID_flush_o, IDEX_bubble_o,
           Hold_o, MEMWB_bubble_o, Err_o, Stall_cnt_o
  );

  modport slave (
    input  IDEX_MemRead_i, IDEX_RDaddr_i, IFID_RSaddr_i, IFID_RTaddr_i,
           Branch_taken_i, DMemReq_i, DMemAck_i,
    output PC_write_o, IFID_write_o, IFID_flush_o, IDEX_bubble_o,
           Hold_o, MEMWB_bubble_o, Err_o, Stall_cnt_o
  );

endinterface

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use dependency check between EX and ID
module hazard_detect
  import pipe_pkg::*;
(
  input  logic       i_mem_read,
  input  logic [4:0] i_rd_addr,
  input  logic [4:0] i_rs_addr,
  input  logic [4:0] i_rt_addr,
  output logic       o_load_use
);

  // r0 is hardwired to zero, so a load targeting it never creates a dependency
  assign o_load_use = i_mem_read && (i_rd_addr != REG_ZERO) &&
                      ((i_rd_addr == i_rs_addr) || (i_rd_addr == i_rt_addr));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline stall/flush/hold control with memory-wait timeout
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  pipe_hazard_ctrl_if.slave bus
);

  localparam int                WAIT_W    = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_W = WAIT_W'(TIMEOUT);

  state_t             r_state;
  state_t             w_state;
  state_t             w_state_next;
  logic [WAIT_W-1:0]  r_wait_cnt;
  logic [WAIT_W-1:0]  w_wait_next;
  logic [WAIT_W-1:0]  w_wait_inc;
  logic               r_err;
  logic [CNT_W-1:0]   r_stall_cnt;
  logic               w_load_use;
  logic               w_holding;
  logic               w_lu_stall;
  logic               w_pc_write;

  hazard_detect u_hazard_detect (
    .i_mem_read (bus.IDEX_MemRead_i),
    .i_rd_addr  (bus.IDEX_RDaddr_i),
    .i_rs_addr  (bus.IFID_RSaddr_i),
    .i_rt_addr  (bus.IFID_RTaddr_i),
    .o_load_use (w_load_use)
  );

  // While reset is asserted the outputs decode as if already in RUN
  assign w_state    = rst_i ? ST_RUN : r_state;
  assign w_wait_inc = r_wait_cnt + 1'b1;

  always_comb begin
    w_state_next = w_state;
    w_wait_next  = r_wait_cnt;
    w_holding    = 1'b0;
    case (w_state)
      ST_RUN: begin
        if (bus.DMemReq_i && !bus.DMemAck_i) begin
          w_holding    = 1'b1;
          w_state_next = ST_MEM_WAIT;
          w_wait_next  = WAIT_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        if (bus.DMemAck_i) begin
          w_state_next = ST_RUN;
          w_wait_next  = '0;
        end else begin
          w_holding   = 1'b1;
          w_wait_next = w_wait_inc;
          if (w_wait_inc == TIMEOUT_W) begin
            w_state_next = ST_ERR;
          end
        end
      end
      ST_ERR: begin
        w_holding = 1'b1;
      end
      default: begin
        w_state_next = ST_RUN;
        w_wait_next  = '0;
      end
    endcase
    w_lu_stall = !w_holding && w_load_use;
    w_pc_write = !(w_holding || w_lu_stall);
  end

  // A taken branch is only flushed when the PC actually advances; otherwise it re-resolves
  assign bus.PC_write_o     = w_pc_write;
  assign bus.IFID_write_o   = w_pc_write;
  assign bus.IFID_flush_o   = w_pc_write && bus.Branch_taken_i;
  assign bus.IDEX_bubble_o  = w_lu_stall;
  assign bus.Hold_o         = w_holding;
  assign bus.MEMWB_bubble_o = w_holding;
  assign bus.Err_o          = r_err;
  assign bus.Stall_cnt_o    = r_stall_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= ST_RUN;
      r_wait_cnt  <= '0;
      r_err       <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_wait_cnt <= w_wait_next;
      r_err      <= (w_state_next == ST_ERR);
      if (!w_pc_write && !(&r_stall_cnt)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(4)) intf ();

  pipe_hazard_ctrl #(.TIMEOUT(4), .CNT_W(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (intf)
  );

  // {PC_write, IFID_write, IFID_flush, IDEX_bubble, Hold, MEMWB_bubble}
  wire [5:0] ctl = {intf.PC_write_o, intf.IFID_write_o, intf.IFID_flush_o,
                    intf.IDEX_bubble_o, intf.Hold_o, intf.MEMWB_bubble_o};

  localparam logic [5:0] C_NORM  = 6'b110000;
  localparam logic [5:0] C_LU    = 6'b000100;
  localparam logic [5:0] C_HOLD  = 6'b000011;
  localparam logic [5:0] C_FLUSH = 6'b111000;

  task automatic drive(input logic mr, input logic [4:0] rd, input logic [4:0] rs,
                       input logic [4:0] rt, input logic br, input logic req, input logic ack);
    @(negedge clk);
    intf.IDEX_MemRead_i = mr;
    intf.IDEX_RDaddr_i  = rd;
    intf.IFID_RSaddr_i  = rs;
    intf.IFID_RTaddr_i  = rt;
    intf.Branch_taken_i = br;
    intf.DMemReq_i      = req;
    intf.DMemAck_i      = ack;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 1, 0);
    total++; if (ctl !== C_HOLD) begin bad++; $display("FAIL reset_run_decode got=%b exp=%b", ctl, C_HOLD); end
    tick();
    total++; if (intf.Err_o !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", intf.Err_o); end
    total++; if (intf.Stall_cnt_o !== 4'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", intf.Stall_cnt_o); end
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    total++; if (ctl !== C_NORM) begin bad++; $display("FAIL reset_idle_ctl got=%b exp=%b", ctl, C_NORM); end
    tick();
    total++; if (intf.Stall_cnt_o !== 4'd0) begin bad++; $display("FAIL reset_idle_cnt got=%0d exp=0", intf.Stall_cnt_o); end
  endtask

  task automatic test_load_use;
    do_reset();
    drive(1, 5, 5, 7, 0, 0, 0);
    total++; if (ctl !== C_LU) begin bad++; $display("FAIL lu_rs_ctl got=%b exp=%b", ctl, C_LU); end
    tick();
    total++; if (intf.Stall_cnt_o !== 4'd1) begin bad++; $display("FAIL lu_rs_cnt got=%0d exp=1", intf.Stall_cnt_o); end
    drive(0, 5, 5, 7, 0, 0, 0);
    total++; if (ctl !== C_NORM) begin bad++; $display("FAIL lu_release_ctl got=%b exp=%b", ctl, C_NORM); end
    tick();
    drive(1, 9, 3, 9, 0, 0, 0);
    total++; if (ctl !== C_LU) begin bad++; $display("FAIL lu_rt_ctl got=%b exp=%b", ctl, C_LU); end
    tick();
    total++; if (intf.Stall_cnt_o !== 4'd2) begin bad++; $display("FAIL lu_rt_cnt got=%0d exp=2", intf.Stall_cnt_o); end
    drive(1, 9, 3, 4, 0, 0, 0);
    total++; if (ctl !== C_NORM) begin bad++; $display("FAIL lu_nomatch_ctl got=%b exp=%b", ctl, C_NORM); end
    tick();
  endtask

  task automatic test_reg_zero;
    drive(1, 0, 0, 0, 0, 0, 0);
    total++; if (ctl !== C_NORM) begin bad++; $display("FAIL r0_ctl got=%b exp=%b", ctl, C_NORM); end
    tick();
    total++; if (intf.Stall_cnt_o !== 4'd2) begin bad++; $display("FAIL r0_cnt got=%0d exp=2", intf.Stall_cnt_o); end
  endtask

  task automatic test_mem_wait;
    do_reset();
    drive(0, 0, 0, 0, 0, 1, 0);
    total++; if (ctl !== C_HOLD) begin bad++; $display("FAIL mw_c1_ctl got=%b exp=%b", ctl, C_HOLD); end
    tick();
    drive(1, 6, 6, 0, 0, 1, 0);
    total++; if (ctl !== C_HOLD) begin bad++; $display("FAIL mw_c2_hold_over_lu got=%b exp=%b", ctl, C_HOLD); end
    tick();
    drive(0, 0, 0, 0, 0, 1, 0);
    total++; if (ctl !== C_HOLD) begin bad++; $display("FAIL mw_c3_ctl got=%b exp=%b", ctl, C_HOLD); end
    tick();
    drive(0, 0, 0, 0, 0, 1, 1);
    total++; if (ctl !== C_NORM) begin bad++; $display("FAIL mw_ack_ctl got=%b exp=%b", ctl, C_NORM); end
    tick();
    total++; if (intf.Stall_cnt_o !== 4'd3) begin bad++; $display("FAIL mw_cnt got=%0d exp=3", intf.Stall_cnt_o); end
    total++; if (intf.Err_o !== 1'b0) begin bad++; $display("FAIL mw_err got=%b exp=0", intf.Err_o); end
    drive(0, 0, 0, 0, 0, 0, 0);
    total++; if (ctl !== C_NORM) begin bad++; $display("FAIL mw_back_in_run got=%b exp=%b", ctl, C_NORM); end
    tick();
    drive(0, 0, 0, 0, 0, 1, 1);
    total++; if (ctl !== C_NORM) begin bad++; $display("FAIL mw_zero_wait got=%b exp=%b", ctl, C_NORM); end
    tick();
    total++; if (intf.Stall_cnt_o !== 4'd3) begin bad++; $display("FAIL mw_zero_wait_cnt got=%0d exp=3", intf.Stall_cnt_o); end
  endtask

  task automatic test_branch;
    do_reset();
    drive(1, 4, 4, 0, 1, 0, 0);
    total++; if (ctl !== C_LU) begin bad++; $display("FAIL br_lu_ctl got=%b exp=%b", ctl, C_LU); end
    tick();
    drive(0, 4, 4, 0, 1, 0, 0);
    total++; if (ctl !== C_FLUSH) begin bad++; $display("FAIL br_alone_ctl got=%b exp=%b", ctl, C_FLUSH); end
    tick();
    drive(0, 0, 0, 0, 1, 1, 0);
    total++; if (ctl !== C_HOLD) begin bad++; $display("FAIL br_hold_ctl got=%b exp=%b", ctl, C_HOLD); end
    tick();
    drive(0, 0, 0, 0, 1, 1, 1);
    total++; if (ctl !== C_FLUSH) begin bad++; $display("FAIL br_ack_ctl got=%b exp=%b", ctl, C_FLUSH); end
    tick();
    total++; if (intf.Stall_cnt_o !== 4'd2) begin bad++; $display("FAIL br_cnt got=%0d exp=2", intf.Stall_cnt_o); end
  endtask

  task automatic test_timeout;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 1, 0);
      tick();
    end
    total++; if (intf.Err_o !== 1'b0) begin bad++; $display("FAIL to_early_err got=%b exp=0", intf.Err_o); end
    drive(0, 0, 0, 0, 0, 1, 0);
    total++; if (ctl !== C_HOLD) begin bad++; $display("FAIL to_c4_ctl got=%b exp=%b", ctl, C_HOLD); end
    tick();
    total++; if (intf.Err_o !== 1'b1) begin bad++; $display("FAIL to_err_set got=%b exp=1", intf.Err_o); end
    total++; if (intf.Stall_cnt_o !== 4'd4) begin bad++; $display("FAIL to_cnt got=%0d exp=4", intf.Stall_cnt_o); end
    drive(0, 0, 0, 0, 1, 0, 1);
    total++; if (ctl !== C_HOLD) begin bad++; $display("FAIL to_err_ctl got=%b exp=%b", ctl, C_HOLD); end
    tick();
    drive(1, 2, 2, 0, 1, 1, 1);
    total++; if (ctl !== C_HOLD) begin bad++; $display("FAIL to_err_ctl2 got=%b exp=%b", ctl, C_HOLD); end
    tick();
    total++; if (intf.Err_o !== 1'b1) begin bad++; $display("FAIL to_err_sticky got=%b exp=1", intf.Err_o); end
    total++; if (intf.Stall_cnt_o !== 4'd6) begin bad++; $display("FAIL to_err_cnt got=%0d exp=6", intf.Stall_cnt_o); end
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    total++; if (ctl !== C_NORM) begin bad++; $display("FAIL to_rst_decode got=%b exp=%b", ctl, C_NORM); end
    tick();
    rst = 1'b0;
    total++; if (intf.Err_o !== 1'b0) begin bad++; $display("FAIL to_rst_err got=%b exp=0", intf.Err_o); end
    total++; if (intf.Stall_cnt_o !== 4'd0) begin bad++; $display("FAIL to_rst_cnt got=%0d exp=0", intf.Stall_cnt_o); end
    drive(0, 0, 0, 0, 0, 0, 0);
    total++; if (ctl !== C_NORM) begin bad++; $display("FAIL to_after_rst_ctl got=%b exp=%b", ctl, C_NORM); end
    tick();
  endtask

  task automatic test_reset_mid_wait;
    do_reset();
    drive(0, 0, 0, 0, 0, 1, 0);
    tick();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    total++; if (ctl !== C_NORM) begin bad++; $display("FAIL rmw_decode got=%b exp=%b", ctl, C_NORM); end
    tick();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    total++; if (ctl !== C_NORM) begin bad++; $display("FAIL rmw_run_ctl got=%b exp=%b", ctl, C_NORM); end
    tick();
    total++; if (intf.Stall_cnt_o !== 4'd0) begin bad++; $display("FAIL rmw_cnt got=%0d exp=0", intf.Stall_cnt_o); end
  endtask

  task automatic test_saturate;
    do_reset();
    for (int i = 0; i < 14; i++) begin
      drive(1, 3, 3, 0, 0, 0, 0);
      tick();
    end
    total++; if (intf.Stall_cnt_o !== 4'd14) begin bad++; $display("FAIL sat_14 got=%0d exp=14", intf.Stall_cnt_o); end
    drive(1, 3, 3, 0, 0, 0, 0);
    tick();
    total++; if (intf.Stall_cnt_o !== 4'd15) begin bad++; $display("FAIL sat_15 got=%0d exp=15", intf.Stall_cnt_o); end
    for (int i = 0; i < 2; i++) begin
      drive(1, 3, 3, 0, 0, 0, 0);
      tick();
    end
    total++; if (intf.Stall_cnt_o !== 4'd15) begin bad++; $display("FAIL sat_hold got=%0d exp=15", intf.Stall_cnt_o); end
  endtask

  initial begin
    intf.IDEX_MemRead_i = 1'b0;
    intf.IDEX_RDaddr_i  = 5'd0;
    intf.IFID_RSaddr_i  = 5'd0;
    intf.IFID_RTaddr_i  = 5'd0;
    intf.Branch_taken_i = 1'b0;
    intf.DMemReq_i      = 1'b0;
    intf.DMemAck_i      = 1'b0;
    test_reset();
    test_load_use();
    test_reg_zero();
    test_mem_wait();
    test_branch();
    test_timeout();
    test_reset_mid_wait();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 64, max cycles waited for data-memory ack before error.
REQ-002 Parameter CNT_W, default 16, width of stall counter.
REQ-003 clk_i  in  1  single clock; all state updates on posedge.
REQ-004 rst_i  in  1  reset, synchronous, active-high.
REQ-005 IDEX_MemRead_i  in  1  instruction in EX is a load.
REQ-006 IDEX_RDaddr_i  in  5  destination register of instruction in EX.
REQ-007 IFID_RSaddr_i, IFID_RTaddr_i  in  5 each  source registers of instruction in ID.
REQ-008 Branch_taken_i  in  1  branch resolved taken in ID this cycle.
REQ-009 DMemReq_i  in  1  MEM stage issues a data-memory access this cycle.
REQ-010 DMemAck_i  in  1  data memory completes the access this cycle.
REQ-011 PC_write_o  out  1  PC update enable.
REQ-012 IFID_write_o  out  1  IF/ID register enable.
REQ-013 IFID_flush_o  out  1  IF/ID loads a NOP.
REQ-014 IDEX_bubble_o  out  1  ID/EX loads zeroed control (RegWrite, Mem2Reg, MemRead, MemWrite = 0).
REQ-015 Hold_o  out  1  freezes ID/EX and EX/MEM registers.
REQ-016 MEMWB_bubble_o  out  1  MEM/WB loads RegWrite=0.
REQ-017 Err_o  out  1  memory timeout error, sticky.
REQ-018 Stall_cnt_o  out  CNT_W  count of cycles with PC_write_o=0.

Function
REQ-019 FSM states RUN, MEM_WAIT, ERR; control outputs combinational from state and inputs; Err_o, Stall_cnt_o, state and wait counter registered.
REQ-020 Priority: ERR > memory wait > load-use > branch flush > normal.
REQ-021 RUN, DMemReq_i=1 and DMemAck_i=0: PC_write_o=0, IFID_write_o=0, Hold_o=1, MEMWB_bubble_o=1; next state MEM_WAIT; wait counter <= 1.
REQ-022 RUN, DMemReq_i=1 and DMemAck_i=1: zero-wait access, no hold, stay RUN.
REQ-023 MEM_WAIT, DMemAck_i=0: same hold outputs as REQ-021; wait counter increments; when counter equals TIMEOUT, next state ERR.
REQ-024 MEM_WAIT, DMemAck_i=1: hold outputs deasserted this cycle (MEM/WB captures the data); next state RUN; wait counter <= 0.
REQ-025 Load-use (not holding): IDEX_MemRead_i=1, IDEX_RDaddr_i!=0, and IDEX_RDaddr_i equals RS or RT -> PC_write_o=0, IFID_write_o=0, IDEX_bubble_o=1 for exactly that cycle; no state change.
REQ-026 Branch_taken_i=1 with no stall/hold: IFID_flush_o=1; flush suppressed whenever PC_write_o=0 (branch re-resolves next cycle).
REQ-027 Normal: PC_write_o=1, IFID_write_o=1, all others 0.
REQ-028 ERR: PC_write_o=0, IFID_write_o=0, Hold_o=1, MEMWB_bubble_o=1, Err_o=1 until reset; inputs ignored.
REQ-029 Stall_cnt_o increments on every cycle with PC_write_o=0; saturates at all-ones.
REQ-030 Register 0 never causes a load-use stall.

Reset
REQ-031 rst_i=1 at posedge: state RUN, wait counter 0, Err_o 0, Stall_cnt_o 0; applies from any state, including mid MEM_WAIT and ERR.
REQ-032 Combinational outputs during reset cycle follow RUN-state decode.

Structure
REQ-033 State encoding (RUN, MEM_WAIT, ERR) and NOP-control constants in shared package pipe_pkg.
REQ-034 Load-use comparison in sub-module hazard_detect (pure combinational); FSM, counters in top.

Verification
REQ-035 IDEX_MemRead_i=1, RDaddr=5, RS=5 -> one cycle PC_write_o=0, IFID_write_o=0, IDEX_bubble_o=1, Stall_cnt_o 0->1.
REQ-036 Same with RDaddr=0, RS=0 -> no stall, PC_write_o=1.
REQ-037 DMemReq_i=1, ack after 3 cycles -> Hold_o=1 for 3 cycles, 0 in ack cycle, Stall_cnt_o=3, state RUN.
REQ-038 Load-use and Branch_taken_i same cycle -> IFID_flush_o=0, IDEX_bubble_o=1; next cycle branch alone -> IFID_flush_o=1.
REQ-039 TIMEOUT=4, no ack -> ERR after 4 wait cycles, Err_o=1 held; rst_i pulse -> RUN, Err_o=0, Stall_cnt_o=0.
REQ-040 Preload near-saturated count (CNT_W=4, 14 stalls then 3 more) -> Stall_cnt_o stops at 15.
